macc_accum: RTL

Pipelined multiply-add-accumulate stage that consumes a stream of operand triples, forms `a*b + c` with full carry, and sums the terms over a frame delimited by `last`. It sits directly downstream of the combinational multiply-add (`{cout,out} = a*b + c`) datapath, registering and accumulating its results into one frame total with a sticky carry-out. Output is a valid/ready result port holding the frame sum, overflow flag and beat count.

---
 rtl/macc_accum.sv | 120 ++++++++++++
 1 files changed

// File: rtl/macc_accum.sv
// Two-stage a*b+c pipeline feeding a frame accumulator with a sticky carry,
// a saturating beat count and a valid/ready result register.
module macc_accum #(
   parameter int N     = 6,
   parameter int ACC_W = 2*(N+1),
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [N:0]       i_a,
   input  logic [N:0]       i_b,
   input  logic [N-1:0]     i_c,
   input  logic             i_last,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [ACC_W-1:0] o_out_sum,
   output logic             o_out_cout,
   output logic [CNT_W-1:0] o_out_beats
);

   // valid bits for S1 (index 1) and S2 (index 2)
   logic [2:1]       r_vld_pipe;
   logic [N:0]       r_s1_a, r_s1_b;
   logic [N-1:0]     r_s1_c;
   logic             r_s1_last;
   logic [ACC_W-1:0] r_s2_term;
   logic             r_s2_tcout;
   logic             r_s2_last;

   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;

   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_cout;
   logic [CNT_W-1:0] r_out_beats;

   logic             w_en;
   logic [ACC_W:0]   w_term;
   logic [ACC_W:0]   w_sum;
   logic             w_ncarry;
   logic [CNT_W-1:0] w_ncnt;
   logic             w_acc_fire;
   logic             w_load;

   // A frame end cannot retire while an unaccepted result still occupies the port.
   assign w_en       = !(r_out_valid && !i_out_ready && r_vld_pipe[2] && r_s2_last);
   assign o_in_ready = w_en;

   assign w_term     = (ACC_W+1)'(r_s1_a) * (ACC_W+1)'(r_s1_b) + (ACC_W+1)'(r_s1_c);
   assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_s2_term);
   assign w_ncarry   = r_ovf | r_s2_tcout | w_sum[ACC_W];
   assign w_ncnt     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_acc_fire = r_vld_pipe[2] && w_en;
   assign w_load     = w_acc_fire && r_s2_last;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld_pipe <= '0;
      end else if (w_en) begin
         r_vld_pipe <= {r_vld_pipe[1], i_in_valid};
      end
   end

   // Datapath registers carry no reset; their valid bits qualify them.
   always_ff @(posedge i_clk) begin
      if (w_en) begin
         r_s1_a     <= i_a;
         r_s1_b     <= i_b;
         r_s1_c     <= i_c;
         r_s1_last  <= i_last;
         r_s2_term  <= w_term[ACC_W-1:0];
         r_s2_tcout <= w_term[ACC_W];
         r_s2_last  <= r_s1_last;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (w_acc_fire) begin
         if (r_s2_last) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= w_ncarry;
            r_cnt <= w_ncnt;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_cout  <= 1'b0;
         r_out_beats <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_sum   <= w_sum[ACC_W-1:0];
         r_out_cout  <= w_ncarry;
         r_out_beats <= w_ncnt;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_out_sum;
   assign o_out_cout  = r_out_cout;
   assign o_out_beats = r_out_beats;

endmodule
